// File: rtl/arf_sequencer.sv
// arf_sequencer: multi-cycle PC/SP/AR command sequencer with stack memory handshake.
module arf_sequencer #(
  parameter logic [15:0] SP_LIMIT = 16'h0000,
  parameter logic [15:0] SP_BASE  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        done,
`ifdef ARF_SEQ_STACK_GUARD_EN
  output logic        err,
`endif
  output logic [15:0] rd_data,
  input  logic [15:0] arf_outc,
  output logic [31:0] arf_I,
  output logic [1:0]  arf_FunSel,
  output logic [2:0]  arf_RegSel,
  output logic [1:0]  arf_OutCSel,
  output logic [1:0]  arf_OutDSel,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata
);
  localparam logic [2:0] IDLE = 3'd0, SP_PRE = 3'd1, MEM = 3'd2, SP_POST = 3'd3, LOAD = 3'd4, DONE = 3'd5;
  localparam logic [2:0] OP_INC = 3'd0, OP_JUMP = 3'd1, OP_PUSH = 3'd2, OP_POP = 3'd3;
  localparam logic [2:0] OP_CALL = 3'd4, OP_RET = 3'd5, OP_LDAR = 3'd6, OP_CLR = 3'd7;
  logic [2:0]  state, state_n, op;
  logic [15:0] data, load_val;
  logic        accept, reject, writes, in_push, in_pop;
  assign accept  = cmd_valid & cmd_ready;
  assign writes  = op == OP_PUSH || op == OP_CALL;
  assign in_push = cmd_op == OP_PUSH || cmd_op == OP_CALL;
  assign in_pop  = cmd_op == OP_POP || cmd_op == OP_RET;
`ifdef ARF_SEQ_STACK_GUARD_EN
  logic rej;
  assign reject = (in_push && arf_outc == SP_LIMIT) || (in_pop && arf_outc == SP_BASE);
  assign err    = done & rej;
  always_ff @(posedge clk)
    if (rst) rej <= 1'b0;
    else if (accept) rej <= reject;
`else
  assign reject = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = !accept ? IDLE : reject ? DONE : in_push ? MEM : in_pop ? SP_PRE : LOAD;
      SP_PRE:  state_n = MEM;
      MEM:     state_n = !mem_ack ? MEM : writes ? SP_POST : op == OP_POP ? DONE : LOAD;
      SP_POST: state_n = op == OP_CALL ? LOAD : DONE;
      LOAD:    state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      op      <= OP_INC;
      data    <= 16'h0000;
      rd_data <= 16'h0000;
    end else begin
      state <= state_n;
      if (accept) begin
        op   <= cmd_op;
        data <= cmd_data;
      end
      if (state == MEM && mem_ack && !writes) rd_data <= mem_rdata;
    end
  end
  assign load_val = op == OP_RET ? rd_data : data;
  always_comb begin
    cmd_ready   = state == IDLE;
    done        = state == DONE;
    mem_req     = state == MEM;
    mem_we      = mem_req & writes;
    mem_wdata   = !mem_we ? 16'h0000 : op == OP_CALL ? arf_outc : data;
    arf_OutCSel = (mem_req && op == OP_CALL) ? 2'b00 : 2'b01;
    arf_OutDSel = 2'b01;
    arf_RegSel  = (state == SP_PRE || state == SP_POST) ? 3'b010 :
                  state != LOAD ? 3'b000 :
                  op == OP_CLR ? 3'b111 : op == OP_LDAR ? 3'b001 : 3'b100;
    arf_FunSel  = state == SP_PRE ? 2'b01 : state == SP_POST ? 2'b00 :
                  state != LOAD ? 2'b10 :
                  op == OP_INC ? 2'b01 : op == OP_CLR ? 2'b11 : 2'b10;
    arf_I       = (state == LOAD && op != OP_INC && op != OP_CLR) ? {16'h0000, load_val} : 32'h0;
  end
endmodule
